rsv_arb6: RTL and testbench

- Six-input round-robin arbiter and output register stage that sits directly upstream of the reservation-stage 6:1 flit mux.
- Selects one valid requester per cycle and drives the 3-bit mux select using the mux encoding.
- Captures the selected flit into a single-entry output register with a valid/ready handshake toward the downstream stage.
- Replaces ad-hoc static select generation in the dec/rsv path.

---
 rtl/rsv_arb6.sv | 112 +++++++++++
 tb/tb_rsv_arb6.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rsv_arb6.sv
// Six-input round-robin arbiter with a single-entry output register feeding the rsv 6:1 flit mux.
// Optional packet lock (hold the grant until a tail flit) is enabled with `define ARB_LOCK_EN.
module rsv_arb6 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           in_valid,
   input  logic [6*WIDTH-1:0]   in_data,
   input  logic [5:0]           in_last,
   output logic [5:0]           in_ready,
   output logic [2:0]           sel,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready,
   output logic [2:0]           out_sel
);

   localparam int unsigned NPORT = 6;
   localparam int unsigned SELW  = 3;

   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  gnt;
   logic             gnt_vld;
   logic             load;
   logic [SELW-1:0]  rr_next;
   logic [3:0]       scan_idx;
   logic [7:0]       valid_ext;
   logic [WIDTH-1:0] flit [8];

   // Pad to 8 entries so a 3-bit index can never select past the array.
   assign valid_ext = {2'b00, in_valid};

   for (genvar i = 0; i < 8; i++) begin : g_flit
      if (i < NPORT) begin : g_port
         assign flit[i] = in_data[i*WIDTH +: WIDTH];
      end else begin : g_pad
         assign flit[i] = '0;
      end
   end

`ifdef ARB_LOCK_EN
   logic            lock;
   logic [SELW-1:0] lock_port;
`else
   logic            unused_last;
   assign unused_last = ^in_last;
`endif

   // Grant: first valid port scanning from rr_ptr, wrapping 5 -> 0.
   always_comb begin
      gnt      = '0;
      gnt_vld  = 1'b0;
      scan_idx = '0;
      for (int unsigned k = 0; k < NPORT; k++) begin
         scan_idx = 4'(rr_ptr) + 4'(k);
         if (scan_idx >= 4'(NPORT)) begin
            scan_idx = scan_idx - 4'(NPORT);
         end
         if (!gnt_vld && valid_ext[scan_idx[2:0]]) begin
            gnt     = scan_idx[2:0];
            gnt_vld = 1'b1;
         end
      end
`ifdef ARB_LOCK_EN
      // A locked port owns the mux even while it is idle.
      if (lock) begin
         gnt     = lock_port;
         gnt_vld = valid_ext[lock_port];
      end
`endif
   end

   assign load     = (!out_valid || out_ready) && gnt_vld && !reset;
   assign in_ready = load ? (6'b000001 << gnt) : 6'b000000;
   assign sel      = gnt_vld ? gnt : 3'b000;
   assign rr_next  = (gnt == 3'd5) ? 3'd0 : gnt + 3'd1;

   // Output register, round-robin pointer and lock state.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
`ifdef ARB_LOCK_EN
         lock      <= 1'b0;
         lock_port <= '0;
`endif
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= flit[gnt];
            out_sel   <= gnt;
`ifdef ARB_LOCK_EN
            if (in_last[gnt]) begin
               lock   <= 1'b0;
               rr_ptr <= rr_next;
            end else begin
               lock      <= 1'b1;
               lock_port <= gnt;
            end
`else
            rr_ptr    <= rr_next;
`endif
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rsv_arb6.sv
// Directed self-checking bench for rsv_arb6 (WIDTH=8); lock expectations follow ARB_LOCK_EN.
module tb_rsv_arb6;

   localparam int unsigned W = 8;

   logic          clk;
   logic          reset;
   logic [5:0]    in_valid;
   logic [6*W-1:0] in_data;
   logic [5:0]    in_last;
   logic [5:0]    in_ready;
   logic [2:0]    sel;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [2:0]    out_sel;

   int checks = 0;
   int errors = 0;

   rsv_arb6 #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .sel(sel), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .out_sel(out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic default_data();
      for (int i = 0; i < 6; i++) in_data[i*W +: W] = 8'(i + 1);
   endtask

   int exp_port[5];
   int p2cnt;
   int p3cnt;
   int ep;
   logic [7:0] exp_d;

   initial begin
      reset     = 1'b1;
      in_valid  = 6'h3F;
      in_last   = 6'h3F;
      out_ready = 1'b1;
      default_data();

      // Reset held two cycles with all ports requesting
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_sel", 32'(out_sel), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);

      // Full load: 0..5 round robin twice
      reset = 1'b0;
      #1;
      for (int k = 0; k < 12; k++) begin
         chk("full_sel", 32'(sel), 32'(k % 6));
         chk("full_in_ready", 32'(in_ready), 32'(6'b1 << (k % 6)));
         tick();
         chk("full_out_valid", 32'(out_valid), 32'h1);
         chk("full_out_data", 32'(out_data), 32'((k % 6) + 1));
         chk("full_out_sel", 32'(out_sel), 32'(k % 6));
      end

      // Wrap/skip: grant 4 leaves rr_ptr at 5, then only ports 0/1
      in_valid = 6'b010000;
      #1;
      chk("wrap_sel4", 32'(sel), 32'd4);
      tick();
      chk("wrap_out_sel4", 32'(out_sel), 32'd4);
      in_valid = 6'b000011;
      #1;
      chk("wrap_sel0", 32'(sel), 32'd0);
      tick();
      chk("wrap_out_data0", 32'(out_data), 32'd1);
      chk("wrap_out_sel0", 32'(out_sel), 32'd0);
      #1;
      chk("wrap_sel1", 32'(sel), 32'd1);
      tick();
      chk("wrap_out_data1", 32'(out_data), 32'd2);
      chk("wrap_out_sel1", 32'(out_sel), 32'd1);

      // Backpressure: stall 4 cycles, rr_ptr frozen at 2
      in_valid  = 6'h3F;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         chk("bp_sel", 32'(sel), 32'd2);
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'h1);
         chk("bp_out_data", 32'(out_data), 32'd2);
         chk("bp_out_sel", 32'(out_sel), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_in_ready", 32'(in_ready), 32'h04);
      tick();
      chk("bp_rel_out_data", 32'(out_data), 32'd3);
      chk("bp_rel_out_sel", 32'(out_sel), 32'd2);

      // Pop without load: valid drops, data/sel hold
      in_valid = 6'b000000;
      #1;
      chk("pop_in_ready", 32'(in_ready), 32'h0);
      chk("pop_sel", 32'(sel), 32'd0);
      tick();
      chk("pop_out_valid", 32'(out_valid), 32'h0);
      chk("pop_out_data", 32'(out_data), 32'd3);
      chk("pop_out_sel", 32'(out_sel), 32'd2);

      // Simultaneous pop and load: no bubble
      in_valid = 6'b000001;
      tick();
      chk("pl_first_sel", 32'(out_sel), 32'd0);
      in_valid = 6'b010000;
      #1;
      chk("pl_in_ready", 32'(in_ready), 32'h10);
      tick();
      chk("pl_out_valid", 32'(out_valid), 32'h1);
      chk("pl_out_sel", 32'(out_sel), 32'd4);
      chk("pl_out_data", 32'(out_data), 32'd5);

      // Packet sequence: port 2 sends last=0,0,1 while port 3 stays valid
`ifdef ARB_LOCK_EN
      exp_port = '{2, 2, 2, 3, 3};
`else
      exp_port = '{2, 3, 2, 3, 2};
`endif
      p2cnt = 0;
      p3cnt = 0;
      for (int k = 0; k < 5; k++) begin
         in_valid = {2'b00, 1'b1, (p2cnt < 3), 2'b00};
         in_last  = 6'h3F;
         in_last[2] = (p2cnt == 2);
         in_data[2*W +: W] = 8'(8'h20 + p2cnt);
         in_data[3*W +: W] = 8'(8'h30 + p3cnt);
         ep = exp_port[k];
         exp_d = (ep == 2) ? 8'(8'h20 + p2cnt) : 8'(8'h30 + p3cnt);
         #1;
         chk("pkt_sel", 32'(sel), 32'(ep));
         tick();
         chk("pkt_out_sel", 32'(out_sel), 32'(ep));
         chk("pkt_out_data", 32'(out_data), 32'(exp_d));
         if (ep == 2) p2cnt++;
         else p3cnt++;
      end

      // Reset mid-transfer discards the held flit and restarts at port 0
      in_last   = 6'h3F;
      default_data();
      out_ready = 1'b0;
      reset     = 1'b1;
      #1;
      chk("mrst_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("mrst_out_valid", 32'(out_valid), 32'h0);
      reset     = 1'b0;
      in_valid  = 6'h3F;
      out_ready = 1'b1;
      #1;
      chk("mrst_sel", 32'(sel), 32'd0);
      tick();
      chk("mrst_out_sel", 32'(out_sel), 32'd0);
      chk("mrst_out_data", 32'(out_data), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
